sprite_pixel_gen: RTL and testbench

//  Generates one 24-bit sprite layer (rover or target) per VGA pixel for alpha_blend (pixel_1/pixel_2).

---
 rtl/sprite_pixel_gen_pkg.sv | 33 +++
 rtl/sprite_pixel_gen_if.sv | 33 +++
 rtl/sprite_pixel_gen_sprite_hit.sv | 38 +++
 rtl/sprite_pixel_gen.sv | 151 +++++++++++++++
 tb/tb_sprite_pixel_gen.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pixel_gen_pkg.sv
//============================================================================
// Module : sprite_pixel_gen_pkg
// Brief  : Display definitions shared by the sprite layer generator: active
//          area, coordinate/pixel widths and the dimmed-colour helper.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package sprite_pixel_gen_pkg;

    localparam int c_H_ACTIVE = 1024;
    localparam int c_V_ACTIVE = 768;
    localparam int c_PIX_W    = 24;
    localparam int c_X_W      = 11;
    localparam int c_Y_W      = 10;

    typedef logic [c_PIX_W-1:0] pixel_t;
    typedef logic [c_X_W-1:0]   xcoord_t;
    typedef logic [c_Y_W-1:0]   ycoord_t;

    typedef struct packed {
        xcoord_t x;
        ycoord_t y;
    } pos_t;

    // Halve every 8-bit channel independently so no bit leaks between channels.
    function automatic pixel_t dim_color(input pixel_t c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_pixel_gen_if.sv
//============================================================================
// Module : sprite_pixel_gen_if
// Brief  : Position update handshake from tracking logic into the sprite
//          generator (valid/ready, top-left coordinate).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface sprite_pixel_gen_if;
    import sprite_pixel_gen_pkg::*;

    logic    pos_valid;
    xcoord_t pos_x;
    ycoord_t pos_y;
    logic    pos_ready;

    modport master (
        output pos_valid,
        output pos_x,
        output pos_y,
        input  pos_ready
    );

    modport slave (
        input  pos_valid,
        input  pos_x,
        input  pos_y,
        output pos_ready
    );

endinterface

`default_nettype wire

// File: rtl/sprite_pixel_gen_sprite_hit.sv
//============================================================================
// Module : sprite_hit
// Brief  : Combinational box test: is the current pixel inside a
//          SPRITE_W x SPRITE_H box whose top-left corner is the origin.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module sprite_hit
    import sprite_pixel_gen_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32
) (
    input  wire xcoord_t i_hcount,
    input  wire ycoord_t i_vcount,
    input  wire xcoord_t i_org_x,
    input  wire ycoord_t i_org_y,
    output logic         o_inside
);

    localparam logic [c_X_W:0] c_W = (c_X_W+1)'(SPRITE_W);
    localparam logic [c_Y_W:0] c_H = (c_Y_W+1)'(SPRITE_H);

    // One extra bit on the far edge: a box near the right/bottom clips
    // instead of wrapping round to coordinate 0.
    logic [c_X_W:0] w_x_end;
    logic [c_Y_W:0] w_y_end;

    assign w_x_end = {1'b0, i_org_x} + c_W;
    assign w_y_end = {1'b0, i_org_y} + c_H;

    assign o_inside = (i_hcount >= i_org_x) && ({1'b0, i_hcount} < w_x_end) &&
                      (i_vcount >= i_org_y) && ({1'b0, i_vcount} < w_y_end);

endmodule

`default_nettype wire

// File: rtl/sprite_pixel_gen.sv
//============================================================================
// Module : sprite_pixel_gen
// Brief  : One 24-bit sprite layer per pixel, 2-cycle latency, position
//          committed only at the start of vertical blank (tear-free).
// Config : SPRITE_BLINK_EN - blink the dimmed (lost) sprite.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module sprite_pixel_gen
    import sprite_pixel_gen_pkg::*;
#(
    parameter int     SPRITE_W     = 32,
    parameter int     SPRITE_H     = 32,
    parameter pixel_t COLOR        = 24'hFF0000,
    parameter int     V_ACTIVE     = c_V_ACTIVE,
    parameter int     LOST_FRAMES  = 60,
    parameter int     BLINK_FRAMES = 16
) (
    input  wire                 clock,
    input  wire                 reset,
    input  wire xcoord_t        hcount,
    input  wire ycoord_t        vcount,
    input  wire                 hsync,
    input  wire                 vsync,
    input  wire                 blank,
    sprite_pixel_gen_if.slave   pos_if,
    output pixel_t              pixel,
    output logic                phsync,
    output logic                pvsync,
    output logic                pblank
);

    localparam int              c_LOST_W   = $clog2(LOST_FRAMES + 1);
    localparam logic [c_LOST_W-1:0] c_LOST_MAX = c_LOST_W'(LOST_FRAMES);
    localparam ycoord_t         c_V_COMMIT = c_Y_W'(V_ACTIVE);

    if (COLOR == '0 || BLINK_FRAMES < 1 ||
        (BLINK_FRAMES & (BLINK_FRAMES - 1)) != 0) begin : g_param_check
        $error("sprite_pixel_gen: COLOR must be nonzero and BLINK_FRAMES a power of two");
    end

    logic                r_pending;
    pos_t                r_shadow;
    pos_t                r_active;
    logic [c_LOST_W-1:0] r_lost_cnt;

    logic r_inside;
    logic r_hsync_d1;
    logic r_vsync_d1;
    logic r_blank_d1;

    logic   w_accept;
    logic   w_commit;
    logic   w_inside;
    logic   w_lost;
    logic   w_blink_off;
    pixel_t w_body;

    assign pos_if.pos_ready = !r_pending;
    assign w_accept         = pos_if.pos_valid && !r_pending;
    assign w_commit         = (hcount == '0) && (vcount == c_V_COMMIT);
    assign w_lost           = (r_lost_cnt == c_LOST_MAX);

    // Position shadow and commit: a committing frame cannot also accept,
    // because ready is low while a value is pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending  <= 1'b0;
            r_shadow   <= '0;
            r_active   <= '0;
            r_lost_cnt <= c_LOST_MAX;
        end else if (w_commit && r_pending) begin
            r_active   <= r_shadow;
            r_pending  <= 1'b0;
            r_lost_cnt <= '0;
        end else begin
            if (w_commit && !w_lost) begin
                r_lost_cnt <= r_lost_cnt + 1'b1;
            end
            if (w_accept) begin
                r_shadow  <= '{x: pos_if.pos_x, y: pos_if.pos_y};
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SPRITE_BLINK_EN
    localparam int c_BLINK_BIT = $clog2(BLINK_FRAMES);

    logic [c_BLINK_BIT:0] r_frame_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_commit) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign w_blink_off = w_lost && r_frame_cnt[c_BLINK_BIT];
`else
    assign w_blink_off = 1'b0;
`endif

    sprite_hit #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_hit (
        .i_hcount (hcount),
        .i_vcount (vcount),
        .i_org_x  (r_active.x),
        .i_org_y  (r_active.y),
        .o_inside (w_inside)
    );

    // Stage 1: box test and first sync delay.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inside   <= 1'b0;
            r_hsync_d1 <= 1'b0;
            r_vsync_d1 <= 1'b0;
            r_blank_d1 <= 1'b0;
        end else begin
            r_inside   <= w_inside;
            r_hsync_d1 <= hsync;
            r_vsync_d1 <= vsync;
            r_blank_d1 <= blank;
        end
    end

    assign w_body = w_lost ? dim_color(COLOR) : COLOR;

    // Stage 2: colour select, aligned with the second sync delay.
    always_ff @(posedge clock) begin
        if (reset) begin
            pixel  <= '0;
            phsync <= 1'b0;
            pvsync <= 1'b0;
            pblank <= 1'b0;
        end else begin
            pixel  <= (r_inside && !r_blank_d1 && !w_blink_off) ? w_body : '0;
            phsync <= r_hsync_d1;
            pvsync <= r_vsync_d1;
            pblank <= r_blank_d1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_pixel_gen.sv
//============================================================================
// Module : tb_sprite_pixel_gen
// Brief  : Self-checking bench for sprite_pixel_gen: directed scenarios then
//          random traffic against a frame-level reference model.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_sprite_pixel_gen;
    import sprite_pixel_gen_pkg::*;

    localparam int     SPRITE_W     = 32;
    localparam int     SPRITE_H     = 32;
    localparam pixel_t COLOR        = 24'hFF0000;
    localparam int     V_ACTIVE     = 768;
    localparam int     LOST_FRAMES  = 60;
    localparam int     BLINK_FRAMES = 16;

    logic    clock = 1'b0;
    logic    reset;
    xcoord_t hcount;
    ycoord_t vcount;
    logic    hsync, vsync, blank;
    pixel_t  pixel;
    logic    phsync, pvsync, pblank;

    sprite_pixel_gen_if pif ();

    sprite_pixel_gen #(
        .SPRITE_W     (SPRITE_W),
        .SPRITE_H     (SPRITE_H),
        .COLOR        (COLOR),
        .V_ACTIVE     (V_ACTIVE),
        .LOST_FRAMES  (LOST_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .hcount (hcount),
        .vcount (vcount),
        .hsync  (hsync),
        .vsync  (vsync),
        .blank  (blank),
        .pos_if (pif.slave),
        .pixel  (pixel),
        .phsync (phsync),
        .pvsync (pvsync),
        .pblank (pblank)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sprite positions and frame-level bookkeeping.
    typedef struct {
        logic [23:0] pix;
        logic        hs, vs, bl;
    } exp_t;

    exp_t exp_q[$];
    int   m_ax, m_ay, m_sx, m_sy, m_lost, m_frames;
    bit   m_pending;

    function automatic logic [23:0] model_body();
        int r, g, b;
        r = int'(COLOR[23:16]);
        g = int'(COLOR[15:8]);
        b = int'(COLOR[7:0]);
        if (m_lost == LOST_FRAMES) begin
`ifdef SPRITE_BLINK_EN
            if (((m_frames / BLINK_FRAMES) % 2) == 1) return 24'h0;
`endif
            r = r / 2; g = g / 2; b = b / 2;
        end
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    task automatic tick();
        exp_t e;
        bit   acc, in_spr, commit;
        int   hc, vc;
        @(posedge clock);
        #1;
        acc = 1'b0;
        if (reset) begin
            if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '{24'h0, 1'b0, 1'b0, 1'b0};
            e = '{24'h0, 1'b0, 1'b0, 1'b0};
            m_pending = 1'b0; m_ax = 0; m_ay = 0;
            m_lost = LOST_FRAMES; m_frames = 0;
        end else begin
            hc = int'(hcount);
            vc = int'(vcount);
            in_spr = (hc >= m_ax) && (hc < m_ax + SPRITE_W) &&
                     (vc >= m_ay) && (vc < m_ay + SPRITE_H);
            commit = (hc == 0) && (vc == V_ACTIVE);
            acc    = pif.pos_valid && !m_pending;
            if (commit && m_pending) begin
                m_ax = m_sx; m_ay = m_sy; m_pending = 1'b0; m_lost = 0;
            end else if (commit && m_lost < LOST_FRAMES) begin
                m_lost++;
            end
            if (commit) m_frames++;
            if (acc) begin
                m_sx = int'(pif.pos_x); m_sy = int'(pif.pos_y); m_pending = 1'b1;
            end
            e.pix = (in_spr && !blank) ? model_body() : 24'h0;
            e.hs = hsync; e.vs = vsync; e.bl = blank;
        end
        exp_q.push_back(e);
        check_eq("pos_ready", 32'(pif.pos_ready), 32'(!m_pending));
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check_eq("pixel", 32'(pixel), 32'(e.pix));
            check_eq("phsync", 32'(phsync), 32'(e.hs));
            check_eq("pvsync", 32'(pvsync), 32'(e.vs));
            check_eq("pblank", 32'(pblank), 32'(e.bl));
        end
        if (acc) pif.pos_valid = 1'b0;
    endtask

    task automatic idle();
        hcount = 11'd1200; vcount = 10'd0; blank = 1'b1;
    endtask

    task automatic commit_frame();
        hcount = 11'd0; vcount = 10'(V_ACTIVE); blank = 1'b1;
        tick();
        idle();
    endtask

    task automatic offer(input int x, input int y);
        pif.pos_valid = 1'b1;
        pif.pos_x = 11'(x);
        pif.pos_y = 10'(y);
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
        hcount = 11'(x); vcount = 10'(y); blank = 1'b0;
        tick();
        idle();
        tick();
        check_eq(tag, 32'(pixel), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; hsync = 1'b0; vsync = 1'b0;
        idle();
        pif.pos_valid = 1'b0; pif.pos_x = '0; pif.pos_y = '0;
        repeat (3) tick();
        check_eq("rst_pixel", 32'(pixel), 32'h0);
        check_eq("rst_ready", 32'(pif.pos_ready), 32'h1);
        reset = 1'b0;

        // Frame with no position: dimmed sprite at the origin.
        commit_frame();
        probe("dim_00", 0, 0, 24'h7F0000);
        probe("dim_32_0", 32, 0, 24'h0);

        // Offer mid-frame: old position still drawn until the commit.
        offer(100, 200);
        tick();
        check_eq("ready_drop", 32'(pif.pos_ready), 32'h0);
        probe("old_pos", 0, 0, 24'h7F0000);
        probe("new_early", 100, 200, 24'h0);
        commit_frame();
        probe("new_tl", 100, 200, 24'hFF0000);
        probe("new_br", 131, 231, 24'hFF0000);
        probe("new_right", 132, 200, 24'h0);

        // Held valid while pending: second value waits for the next commit.
        offer(300, 400);
        tick();
        offer(500, 600);
        repeat (3) tick();
        check_eq("held_ready", 32'(pif.pos_ready), 32'h0);
        commit_frame();
        check_eq("held_wait", 32'(pif.pos_valid), 32'h1);
        tick();
        check_eq("held_taken", 32'(pif.pos_valid), 32'h0);
        probe("first_commit", 300, 400, 24'hFF0000);
        probe("second_not_yet", 500, 600, 24'h0);
        commit_frame();
        probe("second_commit", 500, 600, 24'hFF0000);

        // Edge sprites clip rather than wrap.
        offer(1010, 760);
        tick();
        commit_frame();
        probe("edge_in", 1015, 765, 24'hFF0000);
        probe("edge_x_wrap", 5, 765, 24'h0);
        probe("edge_y_wrap", 1015, 5, 24'h0);
        offer(2040, 1020);
        tick();
        commit_frame();
        probe("far_in", 2045, 1021, 24'hFF0000);
        probe("far_x_wrap", 3, 1020, 24'h0);
        probe("far_y_wrap", 2040, 3, 24'h0);

        // Lost tracking: bright for 59 empty frames, dimmed at the 60th.
        offer(50, 50);
        tick();
        commit_frame();
        repeat (LOST_FRAMES - 1) commit_frame();
        probe("lost_59", 50, 50, 24'hFF0000);
        commit_frame();
        probe("lost_60", 50, 50, 24'h7F0000);

        // Reset during the visible line drops the pending position.
        offer(700, 300);
        tick();
        hcount = 11'd55; vcount = 10'd55; blank = 1'b0; hsync = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0; hsync = 1'b0;
        idle();
        tick();
        check_eq("midrst_pixel", 32'(pixel), 32'h0);
        check_eq("midrst_ready", 32'(pif.pos_ready), 32'h1);
        commit_frame();
        probe("midrst_lost", 700, 300, 24'h0);
        probe("midrst_origin", 0, 0, 24'h7F0000);

        // Random traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                hcount = 11'd0; vcount = 10'(V_ACTIVE);
            end else if (r < 60) begin
                hcount = 11'(m_ax + int'($urandom_range(0, SPRITE_W + 7)) - 4);
                vcount = 10'(m_ay + int'($urandom_range(0, SPRITE_H + 7)) - 4);
            end else begin
                hcount = 11'($urandom_range(0, 2047));
                vcount = 10'($urandom_range(0, 1023));
            end
            blank = ($urandom_range(0, 3) == 0);
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 999) == 0);
            if (!pif.pos_valid && $urandom_range(0, 9) == 0)
                offer(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
